// File: rtl/sprite_palette_pkg.sv
// Shared types and defaults for the sprite palette engine.
// Holds the colour struct, the fade FSM states and the default channel width and key index.
package sprite_palette_pkg;

   localparam int unsigned DEF_COLOR_W   = 4;
   localparam int unsigned DEF_KEY_INDEX = 15;
   localparam logic [DEF_COLOR_W-1:0] CHAN_MAX = {DEF_COLOR_W{1'b1}};

   typedef struct packed {
      logic [DEF_COLOR_W-1:0] r;
      logic [DEF_COLOR_W-1:0] g;
      logic [DEF_COLOR_W-1:0] b;
   } rgb_t;

   typedef enum logic [0:0] {
      IDLE,
      FADING
   } fade_state_t;

endpackage

// File: rtl/sprite_palette_engine_fx_ctrl.sv
// Per-frame effect controller: fade level FSM and hit-flash frame counter.
// Both effects advance on frame_tick only, and they run independently of each other.
module palette_fx_ctrl
   import sprite_palette_pkg::*;
#(
   parameter int unsigned COLOR_W      = DEF_COLOR_W,
   parameter int unsigned FADE_PERIOD  = 2,
   parameter int unsigned FLASH_FRAMES = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_tick,
   input  logic               fade_start,
   input  logic               fade_dir,
   input  logic               flash_trig,
   output logic               fade_busy,
   output logic [COLOR_W-1:0] fade_level,
   output logic               flash_active
);

   localparam int unsigned PCNT_W = (FADE_PERIOD > 1) ? $clog2(FADE_PERIOD) : 1;
   localparam int unsigned FCNT_W = $clog2(FLASH_FRAMES + 1);
   localparam logic [COLOR_W-1:0] LVL_MAX = {COLOR_W{1'b1}};
   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(FADE_PERIOD - 1);

   fade_state_t        state_q, state_d;
   logic [COLOR_W-1:0] level_q, level_d;
   logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
   logic               dir_q, dir_d;
   logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
   logic               at_target;
   logic               last_step;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         level_q <= '0;
         pcnt_q  <= '0;
         dir_q   <= 1'b0;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         pcnt_q  <= pcnt_d;
         dir_q   <= dir_d;
         fcnt_q  <= fcnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      level_d   = level_q;
      pcnt_d    = pcnt_q;
      dir_d     = dir_q;
      at_target = dir_q ? (level_q == LVL_MAX) : (level_q == '0);
      last_step = dir_q ? (level_q == LVL_MAX - 1'b1) : (level_q == {{(COLOR_W-1){1'b0}}, 1'b1});
      // A start keeps the current level so a reversal resumes from where it is.
      if (fade_start) begin
         state_d = FADING;
         pcnt_d  = '0;
         dir_d   = fade_dir;
      end else if (state_q == FADING) begin
         if (at_target) begin
            state_d = IDLE;
         end else if (frame_tick) begin
            if (pcnt_q == PCNT_LAST) begin
               pcnt_d  = '0;
               level_d = dir_q ? (level_q + 1'b1) : (level_q - 1'b1);
               if (last_step) begin
                  state_d = IDLE;
               end
            end else begin
               pcnt_d = pcnt_q + 1'b1;
            end
         end
      end
   end

   always_comb begin
      fcnt_d = fcnt_q;
      if (flash_trig) begin
         fcnt_d = FCNT_W'(FLASH_FRAMES);
      end else if (frame_tick && (fcnt_q != '0)) begin
         fcnt_d = fcnt_q - 1'b1;
      end
   end

   assign fade_busy    = (state_q == FADING);
   assign fade_level   = level_q;
   assign flash_active = (fcnt_q != '0);

endmodule

// File: rtl/sprite_palette_engine.sv
// Banked, writable sprite palette with a 2-stage index-to-RGB pipeline.
// Stage 1 reads the palette; stage 2 applies transparency, hit-flash and fade.
module sprite_palette_engine
   import sprite_palette_pkg::*;
#(
   parameter int unsigned IDX_W        = 4,
   parameter int unsigned NUM_BANKS    = 4,
   parameter int unsigned COLOR_W      = DEF_COLOR_W,
   parameter int unsigned KEY_INDEX    = DEF_KEY_INDEX,
   parameter int unsigned FADE_PERIOD  = 2,
   parameter int unsigned FLASH_FRAMES = 4,
   localparam int unsigned BANK_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
   localparam int unsigned RGB_W       = 3 * COLOR_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic [BANK_W-1:0]  wr_bank,
   input  logic [IDX_W-1:0]   wr_index,
   input  logic [RGB_W-1:0]   wr_rgb,
   input  logic               pix_valid,
   input  logic [BANK_W-1:0]  pix_bank,
   input  logic [IDX_W-1:0]   pix_index,
   input  logic               frame_tick,
   input  logic               fade_start,
   input  logic               fade_dir,
   input  logic               flash_trig,
   output logic               out_valid,
   output logic [COLOR_W-1:0] red,
   output logic [COLOR_W-1:0] green,
   output logic [COLOR_W-1:0] blue,
   output logic               transparent,
   output logic               fade_busy,
   output logic [COLOR_W-1:0] fade_level,
   output logic               flash_active
);

   localparam int unsigned ENTRIES = 2 ** IDX_W;
   localparam logic [COLOR_W-1:0] LVL_MAX = {COLOR_W{1'b1}};

   logic [RGB_W-1:0]   pal_q [NUM_BANKS][ENTRIES];
   logic               s1_valid_q;
   logic               s1_trans_q;
   logic [RGB_W-1:0]   s1_rgb_q;
   logic [COLOR_W-1:0] fx_r, fx_g, fx_b;

   function automatic logic [COLOR_W-1:0] sat_sub(input logic [COLOR_W-1:0] c,
                                                  input logic [COLOR_W-1:0] amt);
      return (c > amt) ? (c - amt) : '0;
   endfunction

   palette_fx_ctrl #(
      .COLOR_W     (COLOR_W),
      .FADE_PERIOD (FADE_PERIOD),
      .FLASH_FRAMES(FLASH_FRAMES)
   ) u_fx_ctrl (
      .clk         (clk),
      .rst         (rst),
      .frame_tick  (frame_tick),
      .fade_start  (fade_start),
      .fade_dir    (fade_dir),
      .flash_trig  (flash_trig),
      .fade_busy   (fade_busy),
      .fade_level  (fade_level),
      .flash_active(flash_active)
   );

   // Non-blocking write means a same-cycle lookup still sees the old entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            for (int e = 0; e < ENTRIES; e++) begin
               pal_q[b][e] <= '0;
            end
         end
      end else if (wr_en) begin
         pal_q[wr_bank][wr_index] <= wr_rgb;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_trans_q <= 1'b0;
         s1_rgb_q   <= '0;
      end else begin
         s1_valid_q <= pix_valid;
         if (pix_valid) begin
            s1_rgb_q   <= pal_q[pix_bank][pix_index];
            s1_trans_q <= (pix_index == IDX_W'(KEY_INDEX));
         end
      end
   end

   always_comb begin
      fx_r = sat_sub(s1_rgb_q[RGB_W-1 -: COLOR_W], fade_level);
      fx_g = sat_sub(s1_rgb_q[2*COLOR_W-1 -: COLOR_W], fade_level);
      fx_b = sat_sub(s1_rgb_q[COLOR_W-1:0], fade_level);
      if (s1_trans_q) begin
         fx_r = '0;
         fx_g = '0;
         fx_b = '0;
      end else if (flash_active) begin
         fx_r = LVL_MAX;
         fx_g = LVL_MAX;
         fx_b = LVL_MAX;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid   <= 1'b0;
         red         <= '0;
         green       <= '0;
         blue        <= '0;
         transparent <= 1'b0;
      end else begin
         out_valid <= s1_valid_q;
         if (s1_valid_q) begin
            red         <= fx_r;
            green       <= fx_g;
            blue        <= fx_b;
            transparent <= s1_trans_q;
         end
      end
   end

endmodule

// File: tb/tb_sprite_palette_engine.sv
// Randomised and directed bench for sprite_palette_engine against a cycle-level reference model.
module tb_sprite_palette_engine;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   logic [1:0] wr_bank;
   logic [3:0] wr_index;
   logic [11:0] wr_rgb;
   logic       pix_valid;
   logic [1:0] pix_bank;
   logic [3:0] pix_index;
   logic       frame_tick, fade_start, fade_dir, flash_trig;
   logic       out_valid, transparent, fade_busy, flash_active;
   logic [3:0] red, green, blue, fade_level;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state, plain integers.
   int pal [4][16];
   int m_s1v, m_s1rgb, m_s1t;
   int e_ov, e_rgb, e_tr;
   int m_lvl, m_fading, m_dir, m_pcnt, m_fcnt;

   always #5 clk = ~clk;

   sprite_palette_engine dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_bank     (wr_bank),
      .wr_index    (wr_index),
      .wr_rgb      (wr_rgb),
      .pix_valid   (pix_valid),
      .pix_bank    (pix_bank),
      .pix_index   (pix_index),
      .frame_tick  (frame_tick),
      .fade_start  (fade_start),
      .fade_dir    (fade_dir),
      .flash_trig  (flash_trig),
      .out_valid   (out_valid),
      .red         (red),
      .green       (green),
      .blue        (blue),
      .transparent (transparent),
      .fade_busy   (fade_busy),
      .fade_level  (fade_level),
      .flash_active(flash_active)
   );

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      wr_en = 0; wr_bank = 0; wr_index = 0; wr_rgb = 0;
      pix_valid = 0; pix_bank = 0; pix_index = 0;
      frame_tick = 0; fade_start = 0; fade_dir = 0; flash_trig = 0;
   endtask

   task automatic model_reset();
      for (int b = 0; b < 4; b++) for (int e = 0; e < 16; e++) pal[b][e] = 0;
      m_s1v = 0; m_s1rgb = 0; m_s1t = 0;
      e_ov = 0; e_rgb = 0; e_tr = 0;
      m_lvl = 0; m_fading = 0; m_dir = 0; m_pcnt = 0; m_fcnt = 0;
   endtask

   function automatic int sat(input int c, input int l);
      return (c > l) ? c - l : 0;
   endfunction

   // Apply the rules for one clock edge, using the inputs present at that edge.
   task automatic model_edge();
      int target;
      e_ov = m_s1v;
      if (m_s1v != 0) begin
         e_tr = m_s1t;
         if (m_s1t != 0) e_rgb = 0;
         else if (m_fcnt > 0) e_rgb = 'hFFF;
         else e_rgb = (sat((m_s1rgb >> 8) & 15, m_lvl) << 8) |
                      (sat((m_s1rgb >> 4) & 15, m_lvl) << 4) |
                       sat(m_s1rgb & 15, m_lvl);
      end
      m_s1v = pix_valid;
      if (pix_valid) begin
         m_s1rgb = pal[pix_bank][pix_index];
         m_s1t   = (pix_index == 15);
      end
      if (wr_en) pal[wr_bank][wr_index] = wr_rgb;
      target = (m_dir != 0) ? 15 : 0;
      if (fade_start) begin
         m_fading = 1; m_pcnt = 0; m_dir = fade_dir;
      end else if (m_fading != 0) begin
         if (m_lvl == target) m_fading = 0;
         else if (frame_tick) begin
            m_pcnt++;
            if (m_pcnt == 2) begin
               m_pcnt = 0;
               m_lvl += (m_dir != 0) ? 1 : -1;
               if (m_lvl == target) m_fading = 0;
            end
         end
      end
      if (flash_trig) m_fcnt = 4;
      else if (frame_tick && m_fcnt > 0) m_fcnt--;
   endtask

   task automatic compare_all();
      check_eq("out_valid", out_valid, e_ov);
      check_eq("rgb", {red, green, blue}, e_rgb);
      check_eq("transparent", transparent, e_tr);
      check_eq("fade_level", fade_level, m_lvl);
      check_eq("fade_busy", fade_busy, m_fading);
      check_eq("flash_active", flash_active, (m_fcnt > 0) ? 1 : 0);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
      clear_inputs();
   endtask

   task automatic frame();
      frame_tick = 1;
      cycle();
      cycle();
   endtask

   task automatic lookup_wait(input int b, input int i);
      pix_valid = 1; pix_bank = 2'(b); pix_index = 4'(i);
      cycle();
      cycle();
   endtask

   task automatic fade_until(input int lvl, input string tag);
      int n = 0;
      while (fade_level != 4'(lvl) && n < 64) begin
         frame();
         n++;
      end
      if (n >= 64) check_eq({tag, "_timeout"}, fade_level, lvl);
   endtask

   initial begin
      clear_inputs();
      model_reset();
      rst = 1;
      #12;
      compare_all();
      @(negedge clk);
      rst = 0;

      // Write then read back with no effects.
      wr_en = 1; wr_bank = 1; wr_index = 3; wr_rgb = 12'hFB3;
      cycle();
      lookup_wait(1, 3);
      check_eq("t1_valid", out_valid, 1);
      check_eq("t1_rgb", {red, green, blue}, 'hFB3);
      check_eq("t1_trans", transparent, 0);

      // Same-cycle write/lookup sees the old entry.
      wr_en = 1; wr_bank = 0; wr_index = 5; wr_rgb = 12'hA41;
      pix_valid = 1; pix_bank = 0; pix_index = 5;
      cycle();
      pix_valid = 1; pix_bank = 0; pix_index = 5;
      cycle();
      check_eq("t2_old", {red, green, blue}, 0);
      cycle();
      check_eq("t2_new", {red, green, blue}, 'hA41);

      // Transparent key, including while flashing.
      wr_en = 1; wr_bank = 3; wr_index = 15; wr_rgb = 12'hF0F;
      cycle();
      lookup_wait(3, 15);
      check_eq("t3_trans", transparent, 1);
      check_eq("t3_rgb", {red, green, blue}, 0);
      flash_trig = 1;
      cycle();
      lookup_wait(3, 15);
      check_eq("t3_flash_on", flash_active, 1);
      check_eq("t3_flash_rgb", {red, green, blue}, 0);
      for (int k = 0; k < 5; k++) frame();

      // Fade out, reverse at 6, then full fade out.
      wr_en = 1; wr_bank = 2; wr_index = 0; wr_rgb = 12'hFEA;
      fade_start = 1; fade_dir = 1;
      cycle();
      fade_until(4, "t4_lvl4");
      lookup_wait(2, 0);
      check_eq("t4_lvl4_rgb", {red, green, blue}, 'hBA6);
      fade_until(6, "t4_lvl6");
      fade_start = 1; fade_dir = 0;
      cycle();
      for (int k = 0; k < 12; k++) frame();
      check_eq("t4_back_lvl", fade_level, 0);
      check_eq("t4_back_busy", fade_busy, 0);
      fade_start = 1; fade_dir = 1;
      cycle();
      for (int k = 0; k < 30; k++) frame();
      check_eq("t4_out_lvl", fade_level, 15);
      check_eq("t4_out_busy", fade_busy, 0);
      lookup_wait(2, 0);
      check_eq("t4_out_rgb", {red, green, blue}, 0);
      fade_start = 1; fade_dir = 0;
      cycle();
      for (int k = 0; k < 30; k++) frame();

      // Flash duration and retrigger.
      flash_trig = 1;
      cycle();
      lookup_wait(1, 3);
      check_eq("t5_rgb", {red, green, blue}, 'hFFF);
      frame(); frame();
      flash_trig = 1;
      cycle();
      for (int k = 0; k < 3; k++) frame();
      check_eq("t5_still_on", flash_active, 1);
      frame();
      check_eq("t5_off", flash_active, 0);

      // Random traffic.
      for (int k = 0; k < 3000; k++) begin
         wr_en      = ($urandom_range(3) == 0);
         wr_bank    = 2'($urandom);
         wr_index   = 4'($urandom);
         wr_rgb     = 12'($urandom);
         pix_valid  = ($urandom_range(1) == 1);
         pix_bank   = 2'($urandom);
         pix_index  = 4'($urandom);
         frame_tick = ($urandom_range(2) == 0);
         fade_start = ($urandom_range(59) == 0);
         fade_dir   = ($urandom_range(1) == 1);
         flash_trig = ($urandom_range(79) == 0);
         cycle();
      end

      // Asynchronous reset mid-fade with a flash running.
      fade_start = 1; fade_dir = 0;
      cycle();
      for (int k = 0; k < 40; k++) frame();
      fade_start = 1; fade_dir = 1;
      cycle();
      fade_until(7, "t6_lvl7");
      flash_trig = 1;
      cycle();
      pix_valid = 1; pix_bank = 1; pix_index = 3;
      cycle();
      pix_valid = 1; pix_bank = 1; pix_index = 3;
      cycle();
      check_eq("t6_pre_flash", flash_active, 1);
      #2 rst = 1;
      #1;
      check_eq("t6_rst_lvl", fade_level, 0);
      check_eq("t6_rst_busy", fade_busy, 0);
      check_eq("t6_rst_flash", flash_active, 0);
      check_eq("t6_rst_valid", out_valid, 0);
      check_eq("t6_rst_rgb", {red, green, blue}, 0);
      check_eq("t6_rst_trans", transparent, 0);
      model_reset();
      @(negedge clk);
      rst = 0;
      lookup_wait(1, 3);
      check_eq("t6_pal_b1", {red, green, blue}, 0);
      lookup_wait(0, 5);
      check_eq("t6_pal_b0", {red, green, blue}, 0);
      check_eq("t6_pal_valid", out_valid, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
